pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/pipeline_ctrl_hazard_detect.sv | 16 +
 rtl/pipeline_ctrl.sv | 130 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipeline_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      DM_WAIT = 1'b1
   } state_e;

   localparam int REG_W          = 5;
   localparam int DM_TIMEOUT_DEF = 16;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use hazard detection between EX (load) and ID (consumer).
module hazard_detect
   import pipeline_pkg::*;
(
   input  logic             mem_read_ex_i,
   input  logic [REG_W-1:0] reg_rt_ex_i,
   input  logic [REG_W-1:0] reg_rs_id_i,
   input  logic [REG_W-1:0] reg_rt_id_i,
   output logic             load_use_o
);

   // r0 is hard-wired zero, so a load targeting it never creates a dependency.
   assign load_use_o = mem_read_ex_i && (reg_rt_ex_i != '0) &&
                       ((reg_rt_ex_i == reg_rs_id_i) || (reg_rt_ex_i == reg_rt_id_i));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: data-memory wait FSM, load-use and branch handling.
module pipeline_ctrl
   import pipeline_pkg::*;
#(
   parameter int DM_TIMEOUT = DM_TIMEOUT_DEF,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             memReadEX,
   input  logic [REG_W-1:0] registerRtEX,
   input  logic [REG_W-1:0] registerRsID,
   input  logic [REG_W-1:0] registerRtID,
   input  logic             branchTakenID,
   input  logic             dmReqMEM,
   input  logic             dmAck,
   input  logic             statClear,
   output logic             pcWrite,
   output logic             ifIdWrite,
   output logic             idExWrite,
   output logic             exMemWrite,
   output logic             memWbWrite,
   output logic             ifIdFlush,
   output logic             idExFlush,
   output logic             memWbBubble,
   output logic             dmTimeout,
   output logic [CNT_W-1:0] stallCycles
);

   localparam int WC_W = $clog2(DM_TIMEOUT + 1);

   state_e            state_q, state_d;
   logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              tmo_q, tmo_d;
   logic              load_use, dm_release, dm_stall;

   hazard_detect u_hazard (
      .mem_read_ex_i (memReadEX),
      .reg_rt_ex_i   (registerRtEX),
      .reg_rs_id_i   (registerRsID),
      .reg_rt_id_i   (registerRtID),
      .load_use_o    (load_use)
   );

   // The cycle that raises the request counts as the first wait cycle, so a
   // silent memory is released on the DM_TIMEOUT-th cycle of the request.
   assign dm_release = (state_q == DM_WAIT) && (wait_cnt_q == WC_W'(DM_TIMEOUT - 1));
   assign dm_stall   = dmReqMEM && !dmAck && !dm_release;

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         RUN: begin
            wait_cnt_d = '0;
            if (dm_stall) begin
               state_d    = DM_WAIT;
               wait_cnt_d = WC_W'(1);
            end
         end
         DM_WAIT: begin
            if (dm_stall) begin
               wait_cnt_d = wait_cnt_q + WC_W'(1);
            end else begin
               state_d    = RUN;
               wait_cnt_d = '0;
            end
         end
         default: begin
            state_d    = RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      tmo_d       = tmo_q | dm_release;
      if ((dm_stall || load_use) && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (statClear) begin
         stall_cnt_d = '0;
         tmo_d       = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         stall_cnt_q <= '0;
         tmo_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         tmo_q       <= tmo_d;
      end
   end

   // Priority: reset, memory stall, load-use, taken branch.
   always_comb begin
      pcWrite     = 1'b1;
      ifIdWrite   = 1'b1;
      idExWrite   = 1'b1;
      exMemWrite  = 1'b1;
      memWbWrite  = 1'b1;
      ifIdFlush   = 1'b0;
      idExFlush   = 1'b0;
      memWbBubble = 1'b0;
      if (!rst_n) begin
         {pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite} = '0;
         {ifIdFlush, idExFlush, memWbBubble}                     = '1;
      end else if (dm_stall) begin
         {pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite} = '0;
         memWbBubble = 1'b1;
      end else if (load_use) begin
         pcWrite   = 1'b0;
         ifIdWrite = 1'b0;
         idExFlush = 1'b1;
      end else if (branchTakenID) begin
         ifIdFlush = 1'b1;
      end
   end

   assign dmTimeout   = tmo_q;
   assign stallCycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench: vector table for single-cycle hazards plus hand sequences for waits/reset.
module tb_pipeline_ctrl;

   logic       clk, rst_n;
   logic       memReadEX, branchTakenID, dmReqMEM, dmAck, statClear;
   logic [4:0] registerRtEX, registerRsID, registerRtID;

   logic        pcW, ifW, idW, exW, wbW, ifF, idF, wbB, tmo;
   logic        pcW4, ifW4, idW4, exW4, wbW4, ifF4, idF4, wbB4, tmo4;
   logic [15:0] cnt;
   logic [2:0]  cnt4;
   logic [7:0]  ctl, ctl4;

   assign ctl  = {pcW, ifW, idW, exW, wbW, ifF, idF, wbB};
   assign ctl4 = {pcW4, ifW4, idW4, exW4, wbW4, ifF4, idF4, wbB4};

   localparam logic [7:0] NORM = 8'b11111_000;
   localparam logic [7:0] LU   = 8'b00111_010;
   localparam logic [7:0] BR   = 8'b11111_100;
   localparam logic [7:0] DMS  = 8'b00000_001;
   localparam logic [7:0] RST  = 8'b00000_111;

   pipeline_ctrl dut (
      .clk(clk), .rst_n(rst_n), .memReadEX(memReadEX), .registerRtEX(registerRtEX),
      .registerRsID(registerRsID), .registerRtID(registerRtID), .branchTakenID(branchTakenID),
      .dmReqMEM(dmReqMEM), .dmAck(dmAck), .statClear(statClear),
      .pcWrite(pcW), .ifIdWrite(ifW), .idExWrite(idW), .exMemWrite(exW), .memWbWrite(wbW),
      .ifIdFlush(ifF), .idExFlush(idF), .memWbBubble(wbB), .dmTimeout(tmo), .stallCycles(cnt)
   );

   pipeline_ctrl #(.DM_TIMEOUT(4), .CNT_W(3)) dut4 (
      .clk(clk), .rst_n(rst_n), .memReadEX(memReadEX), .registerRtEX(registerRtEX),
      .registerRsID(registerRsID), .registerRtID(registerRtID), .branchTakenID(branchTakenID),
      .dmReqMEM(dmReqMEM), .dmAck(dmAck), .statClear(statClear),
      .pcWrite(pcW4), .ifIdWrite(ifW4), .idExWrite(idW4), .exMemWrite(exW4), .memWbWrite(wbW4),
      .ifIdFlush(ifF4), .idExFlush(idF4), .memWbBubble(wbB4), .dmTimeout(tmo4), .stallCycles(cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       mr;
      logic [4:0] rtex, rsid, rtid;
      logic       br, dreq, dack;
      logic [7:0] ctl;
      int         inc;
   } vec_t;

   vec_t vt[12];
   int   n_vec = 0;
   int   n_bad = 0;
   int   exp_cnt;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Called at posedge+1: check combinational controls mid-cycle, then advance one edge.
   task automatic tick(input string nm, input logic [7:0] e, input logic [7:0] e4);
      #3;
      chk(nm, {24'd0, ctl}, {24'd0, e});
      chk({nm, "_t4"}, {24'd0, ctl4}, {24'd0, e4});
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      memReadEX = 0; registerRtEX = 0; registerRsID = 0; registerRtID = 0;
      branchTakenID = 0; dmReqMEM = 0; dmAck = 0; statClear = 0;
   endtask

   task automatic load_use_in();
      memReadEX = 1; registerRtEX = 5'd8; registerRsID = 5'd8; registerRtID = 5'd3;
   endtask

   initial begin
      //        mr  rtex   rsid   rtid   br  dreq dack ctl  inc
      vt[0]  = '{0, 5'd0,  5'd0,  5'd0,  0,  0,   0,   NORM, 0};
      vt[1]  = '{1, 5'd8,  5'd8,  5'd2,  0,  0,   0,   LU,   1};
      vt[2]  = '{1, 5'd8,  5'd4,  5'd8,  0,  0,   0,   LU,   1};
      vt[3]  = '{1, 5'd0,  5'd0,  5'd0,  0,  0,   0,   NORM, 0};
      vt[4]  = '{0, 5'd8,  5'd8,  5'd8,  0,  0,   0,   NORM, 0};
      vt[5]  = '{1, 5'd8,  5'd7,  5'd9,  0,  0,   0,   NORM, 0};
      vt[6]  = '{0, 5'd0,  5'd0,  5'd0,  1,  0,   0,   BR,   0};
      vt[7]  = '{1, 5'd8,  5'd8,  5'd1,  1,  0,   0,   LU,   1};
      vt[8]  = '{0, 5'd8,  5'd8,  5'd1,  1,  0,   0,   BR,   0};
      vt[9]  = '{0, 5'd0,  5'd0,  5'd0,  0,  1,   1,   NORM, 0};
      vt[10] = '{1, 5'd31, 5'd1,  5'd31, 0,  1,   1,   LU,   1};
      vt[11] = '{1, 5'd31, 5'd31, 5'd0,  0,  0,   0,   LU,   1};

      idle();
      rst_n = 1'b0;
      #2;
      chk("rst_ctl", {24'd0, ctl}, {24'd0, RST});
      chk("rst_cnt", {16'd0, cnt}, 32'd0);
      chk("rst_tmo", {31'd0, tmo}, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick("post_rst", NORM, NORM);

      exp_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         memReadEX = vt[i].mr; registerRtEX = vt[i].rtex;
         registerRsID = vt[i].rsid; registerRtID = vt[i].rtid;
         branchTakenID = vt[i].br; dmReqMEM = vt[i].dreq; dmAck = vt[i].dack;
         tick($sformatf("vec%0d", i), vt[i].ctl, vt[i].ctl);
         exp_cnt += vt[i].inc;
         chk($sformatf("vec%0d_cnt", i), {16'd0, cnt}, exp_cnt);
      end

      // Clear beats a same-cycle increment; then counter saturation on the narrow instance.
      idle(); load_use_in(); statClear = 1;
      tick("clr_lu", LU, LU);
      chk("clr_wins", {16'd0, cnt}, 32'd0);
      chk("clr_wins4", {29'd0, cnt4}, 32'd0);
      statClear = 0;
      for (int k = 0; k < 9; k++) tick("sat_lu", LU, LU);
      chk("cnt_9", {16'd0, cnt}, 32'd9);
      chk("cnt4_sat", {29'd0, cnt4}, 32'd7);
      idle(); statClear = 1;
      tick("clr2", NORM, NORM);
      chk("clr2_cnt", {16'd0, cnt}, 32'd0);
      statClear = 0;

      // Memory acks on the 4th requesting cycle.
      dmReqMEM = 1;
      for (int k = 0; k < 3; k++) tick("dm_wait", DMS, DMS);
      dmAck = 1;
      tick("dm_ack", NORM, NORM);
      chk("dm_ack_cnt", {16'd0, cnt}, 32'd3);
      chk("dm_ack_tmo", {31'd0, tmo}, 32'd0);
      idle();
      tick("dm_after", NORM, NORM);
      statClear = 1;
      tick("clr3", NORM, NORM);
      chk("clr3_tmo4", {31'd0, tmo4}, 32'd0);
      statClear = 0;

      // No ack: short-timeout instance releases on cycle 4, default one keeps waiting.
      dmReqMEM = 1;
      for (int k = 0; k < 3; k++) tick("to_wait", DMS, DMS);
      chk("to_tmo_pre", {31'd0, tmo4}, 32'd0);
      tick("to_rel", DMS, NORM);
      chk("to_tmo_set", {31'd0, tmo4}, 32'd1);
      chk("to_tmo_def", {31'd0, tmo}, 32'd0);
      chk("to_cnt", {16'd0, cnt}, 32'd4);
      dmReqMEM = 0;
      tick("req_drop", NORM, NORM);
      tick("idle_sticky", NORM, NORM);
      chk("tmo_sticky", {31'd0, tmo4}, 32'd1);
      statClear = 1;
      tick("clr_tmo", NORM, NORM);
      chk("tmo_cleared", {31'd0, tmo4}, 32'd0);
      statClear = 0;

      // Reset asserted during the second cycle of a memory wait.
      dmReqMEM = 1;
      tick("rw1", DMS, DMS);
      chk("rw1_cnt", {16'd0, cnt}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rw_rst_ctl", {24'd0, ctl}, {24'd0, RST});
      chk("rw_rst_cnt", {16'd0, cnt}, 32'd0);
      chk("rw_rst_tmo", {31'd0, tmo}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      dmReqMEM = 0;
      tick("rw_post", NORM, NORM);
      chk("rw_post_cnt", {16'd0, cnt}, 32'd0);
      chk("rw_post_tmo", {31'd0, tmo}, 32'd0);
      dmReqMEM = 1; dmAck = 1;
      tick("rw_run", NORM, NORM);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
